// File: rtl/imem_uart_loader_if.sv
// Instruction RAM write port driven by the UART program loader.
// The loader owns the master side; the RAM (or a bench monitor) takes the slave side.
interface imem_uart_loader_if #(
   parameter int unsigned ADDR_W = 12
);
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;

   modport master (output we, addr, wdata);
   modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/imem_uart_loader.sv
// Receives a program over an 8N1 UART line, packs it into 32-bit little-endian words and writes
// them to the instruction RAM, holding the CPU in reset while a frame is being loaded.
module imem_uart_loader #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned TIMEOUT_CLKS = 5000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                uart_rx,
   imem_uart_loader_if.master  mem,
   output logic                cpu_rst_n,
   output logic                busy,
   output logic                done,
   output logic                err
);
   localparam int unsigned TimerW  = $clog2(CLKS_PER_BIT);
   localparam int unsigned HalfBit = CLKS_PER_BIT / 2;
   localparam int unsigned ToW     = $clog2(TIMEOUT_CLKS + 1);
   localparam int unsigned Depth   = 1 << ADDR_W;

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
   typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StFinish, StAbort} ld_state_e;

   rx_state_e         rx_state;
   logic              rx_meta, rx_sync, rx_prev;
   logic [TimerW-1:0] rx_timer;
   logic [2:0]        rx_bit;
   logic [7:0]        rx_shift;
   logic              byte_valid, frame_err;

   // Receiver; rx_shift holds the received byte until the next byte's data bits arrive.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_prev    <= 1'b1;
         rx_state   <= RxIdle;
         rx_timer   <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_meta    <= uart_rx;
         rx_sync    <= rx_meta;
         rx_prev    <= rx_sync;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (rx_state)
            RxIdle: begin
               if (!rx_sync && rx_prev) begin
                  rx_timer <= '0;
                  rx_state <= RxStart;
               end
            end
            RxStart: begin
               if (rx_timer == TimerW'(HalfBit - 1)) begin
                  rx_timer <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_sync ? RxIdle : RxData;
               end else begin
                  rx_timer <= rx_timer + 1'b1;
               end
            end
            RxData: begin
               if (rx_timer == TimerW'(CLKS_PER_BIT - 1)) begin
                  rx_timer <= '0;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  if (rx_bit == 3'd7) rx_state <= RxStop;
                  else                rx_bit   <= rx_bit + 1'b1;
               end else begin
                  rx_timer <= rx_timer + 1'b1;
               end
            end
            RxStop: begin
               if (rx_timer == TimerW'(CLKS_PER_BIT - 1)) begin
                  rx_timer <= '0;
                  rx_state <= RxIdle;
                  if (rx_sync) byte_valid <= 1'b1;
                  else         frame_err  <= 1'b1;
               end else begin
                  rx_timer <= rx_timer + 1'b1;
               end
            end
            default: rx_state <= RxIdle;
         endcase
      end
   end

   ld_state_e       state;
   logic [15:0]     len_q;
   logic [15:0]     len_next;
   logic [ADDR_W:0] word_cnt;
   logic [1:0]      byte_idx;
   logic [23:0]     word_buf;
   logic [ToW-1:0]  to_cnt;
   logic            timeout_hit;
   logic            abort_now;

   assign len_next    = {rx_shift, len_q[7:0]};
   assign timeout_hit = busy && (to_cnt == ToW'(TIMEOUT_CLKS));
   assign abort_now   = busy && (frame_err || timeout_hit);

   // Flags are updated on the transition into FINISH/ABORT so they appear one cycle after the byte.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= StIdle;
         len_q     <= '0;
         word_cnt  <= '0;
         byte_idx  <= '0;
         word_buf  <= '0;
         to_cnt    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         cpu_rst_n <= 1'b0;
         mem.we    <= 1'b0;
         mem.addr  <= '0;
         mem.wdata <= '0;
      end else begin
         mem.we    <= 1'b0;
         cpu_rst_n <= ~busy & ~err;
         if (byte_valid || !busy) to_cnt <= '0;
         else                     to_cnt <= to_cnt + 1'b1;

         if (abort_now) begin
            state <= StAbort;
            busy  <= 1'b0;
            err   <= 1'b1;
         end else begin
            case (state)
               StIdle: begin
                  if (byte_valid && rx_shift == 8'hA5) begin
                     state <= StLenLo;
                     busy  <= 1'b1;
                     err   <= 1'b0;
                     done  <= 1'b0;
                  end
               end
               StLenLo: begin
                  if (byte_valid) begin
                     len_q[7:0] <= rx_shift;
                     state      <= StLenHi;
                  end
               end
               StLenHi: begin
                  if (byte_valid) begin
                     len_q <= len_next;
                     if (len_next == 16'd0) begin
                        state <= StFinish;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else if (32'(len_next) > Depth) begin
                        state <= StAbort;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                     end else begin
                        word_cnt <= '0;
                        byte_idx <= '0;
                        state    <= StData;
                     end
                  end
               end
               StData: begin
                  if (byte_valid) begin
                     byte_idx <= byte_idx + 1'b1;
                     unique case (byte_idx)
                        2'd0: word_buf[7:0]   <= rx_shift;
                        2'd1: word_buf[15:8]  <= rx_shift;
                        2'd2: word_buf[23:16] <= rx_shift;
                        2'd3: begin
                           mem.we    <= 1'b1;
                           mem.addr  <= word_cnt[ADDR_W-1:0];
                           mem.wdata <= {rx_shift, word_buf};
                           word_cnt  <= word_cnt + 1'b1;
                           if (32'(word_cnt) + 32'd1 == 32'(len_q)) begin
                              state <= StFinish;
                              busy  <= 1'b0;
                              done  <= 1'b1;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
               StFinish: state <= StIdle;
               StAbort:  state <= StIdle;
               default:  state <= StIdle;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_imem_uart_loader.sv
// Scoreboarded bench for the UART program loader: expected RAM writes are queued by the
// stimulus and checked by an independent write-port monitor.
module tb_imem_uart_loader;
   localparam int unsigned Cpb  = 8;
   localparam int unsigned AddrW = 12;
   localparam int unsigned ToClks = 300;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic uart_rx = 1'b1;
   logic cpu_rst_n, busy, done, err;

   imem_uart_loader_if #(.ADDR_W(AddrW)) mem_if ();

   imem_uart_loader #(
      .CLKS_PER_BIT (Cpb),
      .ADDR_W       (AddrW),
      .TIMEOUT_CLKS (ToClks)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .uart_rx   (uart_rx),
      .mem       (mem_if),
      .cpu_rst_n (cpu_rst_n),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AddrW-1:0] addr;
      logic [31:0]      data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   logic prev_we = 1'b0;

   always @(negedge clk) begin
      if (rst_n && mem_if.we) begin
         checks++;
         if (prev_we) begin
            errors++;
            $display("FAIL we_double got=2 consecutive cycles exp=1");
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write got addr=%h data=%h exp=none", mem_if.addr,
                     mem_if.wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (mem_if.addr !== e.addr || mem_if.wdata !== e.data) begin
               errors++;
               $display("FAIL write got addr=%h data=%h exp addr=%h data=%h", mem_if.addr,
                        mem_if.wdata, e.addr, e.data);
            end
         end
      end
      prev_we = mem_if.we;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (Cpb) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (Cpb) @(posedge clk);
      end
      uart_rx = stop;
      repeat (Cpb) @(posedge clk);
      uart_rx = 1'b1;
      repeat (Cpb) @(posedge clk);
   endtask

   task automatic push(input logic [AddrW-1:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic send_good_frame();
      logic [7:0] bytes [11];
      bytes = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      push(12'd0, 32'h0000_0013);
      push(12'd1, 32'h0010_0093);
      for (int i = 0; i < 11; i++) send_byte(bytes[i], 1'b1);
   endtask

   initial begin
      // Reset state
      cycles(5);
      chk("rst_we", {31'd0, mem_if.we}, 32'd0);
      chk("rst_addr", {20'd0, mem_if.addr}, 32'd0);
      chk("rst_wdata", mem_if.wdata, 32'd0);
      chk("rst_flags", {28'd0, busy, done, err, cpu_rst_n}, 32'd0);
      rst_n = 1'b1;
      cycles(3);
      chk("post_rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);

      // Good two-word frame, CPU held in reset while loading
      push(12'd0, 32'h0000_0013);
      push(12'd1, 32'h0010_0093);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      cycles(2);
      chk("load_busy", {31'd0, busy}, 32'd1);
      chk("load_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      send_byte(8'h13, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h93, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h10, 1'b1);
      send_byte(8'h00, 1'b1);
      cycles(10);
      chk("good_flags", {29'd0, busy, done, err}, 32'b010);
      chk("good_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
      chk("good_q_drained", exp_q.size(), 32'd0);

      // Zero-length frame
      send_byte(8'hA5, 1'b1);
      cycles(2);
      chk("zero_start_flags", {29'd0, busy, done, err}, 32'b100);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      cycles(4);
      chk("zero_flags", {29'd0, busy, done, err}, 32'b010);
      chk("zero_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);

      // Oversize length 0x2001
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h20, 1'b1);
      cycles(4);
      chk("oversize_flags", {29'd0, busy, done, err}, 32'b001);
      chk("oversize_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);

      // Framing error on the 3rd data byte, then a clean reload
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h13, 1'b1);
      send_byte(8'h00, 1'b1);
      chk("ferr_pre_flags", {29'd0, busy, done, err}, 32'b100);
      send_byte(8'h00, 1'b0);
      cycles(4);
      chk("ferr_flags", {29'd0, busy, done, err}, 32'b001);
      chk("ferr_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      send_good_frame();
      cycles(10);
      chk("reload_flags", {29'd0, busy, done, err}, 32'b010);
      chk("reload_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);

      // Junk bytes and a short start glitch while idle
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'h12, 1'b1);
      uart_rx = 1'b0;
      cycles(2);
      uart_rx = 1'b1;
      cycles(40);
      chk("glitch_flags", {29'd0, busy, done, err}, 32'b010);
      chk("glitch_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);

      // Inter-byte timeout
      send_byte(8'hA5, 1'b1);
      cycles(2);
      chk("to_start_busy", {31'd0, busy}, 32'd1);
      cycles(ToClks + 50);
      chk("to_flags", {29'd0, busy, done, err}, 32'b001);
      chk("to_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);

      // Reset in the middle of a word, then a full reload
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      rst_n = 1'b0;
      cycles(2);
      chk("midrst_addr", {20'd0, mem_if.addr}, 32'd0);
      chk("midrst_wdata", mem_if.wdata, 32'd0);
      chk("midrst_flags", {28'd0, busy, done, err, cpu_rst_n}, 32'd0);
      rst_n = 1'b1;
      cycles(3);
      chk("midrst_cpu_run", {31'd0, cpu_rst_n}, 32'd1);
      send_good_frame();
      cycles(10);
      chk("final_flags", {29'd0, busy, done, err}, 32'b010);
      chk("final_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
      chk("final_q_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
